// File: rtl/lsu_pkg.sv
// Load/store unit types plus the helpers used by the data-memory responder:
// byte-enable generation, load extension, store lane replication and alignment checks.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_LB,
        LSU_LH,
        LSU_LW,
        LSU_LBU,
        LSU_LHU,
        LSU_SB,
        LSU_SH,
        LSU_SW
    } lsuop_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    function automatic logic [3:0] gen_be_f(lsuop_t op, logic [1:0] a);
        logic [3:0] be;
        be = 4'b1111;
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: be = 4'b0001 << a;
            LSU_LH, LSU_LHU, LSU_SH: be = a[1] ? 4'b1100 : 4'b0011;
            default:                 be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] ext_load_f(lsuop_t op, logic [1:0] a, logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (op)
            LSU_LB:  r = {{24{b[7]}}, b};
            LSU_LBU: r = {24'h0, b};
            LSU_LH:  r = {{16{h[15]}}, h};
            LSU_LHU: r = {16'h0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replicate the store byte/half onto every lane; the byte enables pick the live ones.
    function automatic logic [31:0] store_data_f(lsuop_t op, logic [31:0] wd);
        logic [31:0] r;
        case (op)
            LSU_SB:  r = {4{wd[7:0]}};
            LSU_SH:  r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic misaligned_f(lsuop_t op, logic [1:0] a);
        logic m;
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: m = a[0];
            LSU_LW, LSU_SW:          m = (a != 2'b00);
            default:                 m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with per-byte write enables and a registered read port.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// then performs the access and presents a one-cycle response while holding stall.
module dmem_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dm_rd_en,
    input  logic        dm_wr_en,
    input  lsuop_t      lsuop,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        latch_en;

    lsuop_t      op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        wr_q;
    logic        bad_q;
    logic        err_q;

    lsuop_t      cur_op;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_wr;
    logic        cur_bad;
    logic        acc_err;
    logic        enter_resp;
    logic        mem_en;
    logic [3:0]  mem_be;
    logic [31:0] ram_rdata;
    logic        unused_addr_hi;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        case (state_q)
            IDLE: begin
                // Both enables high still gets accepted, as an error request.
                if (dm_rd_en || dm_wr_en) begin
                    latch_en = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign stall     = ((state_q == IDLE) && (dm_rd_en || dm_wr_en)) || (state_q == WAIT);
    assign rsp_valid = (state_q == RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            op_q    <= lsuop;
            addr_q  <= addr;
            wdata_q <= wdata;
            wr_q    <= dm_wr_en;
            bad_q   <= dm_rd_en & dm_wr_en;
        end
    end

    // With zero wait states the access happens on the accepting edge, so the
    // request fields must come straight from the inputs rather than the latch.
    assign cur_op    = (state_q == IDLE) ? lsuop : op_q;
    assign cur_addr  = (state_q == IDLE) ? addr : addr_q;
    assign cur_wdata = (state_q == IDLE) ? wdata : wdata_q;
    assign cur_wr    = (state_q == IDLE) ? dm_wr_en : wr_q;
    assign cur_bad   = (state_q == IDLE) ? (dm_rd_en & dm_wr_en) : bad_q;

    assign acc_err        = cur_bad | misaligned_f(cur_op, cur_addr[1:0]);
    assign enter_resp     = (state_d == RESP) && rst_n;
    assign mem_en         = enter_resp && !acc_err;
    assign mem_be         = (mem_en && cur_wr) ? gen_be_f(cur_op, cur_addr[1:0]) : 4'b0000;
    assign unused_addr_hi = ^cur_addr[31:AW+2];

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk),
        .en_i    (mem_en),
        .be_i    (mem_be),
        .idx_i   (cur_addr[AW+1:2]),
        .wdata_i (store_data_f(cur_op, cur_wdata)),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (enter_resp) begin
            err_q <= acc_err;
        end else if (state_q == RESP) begin
            err_q <= 1'b0;
        end
    end

    // The RAM output register holds the loaded word for the RESP cycle only.
    assign rdata = ((state_q == RESP) && !err_q && !wr_q)
                   ? ext_load_f(op_q, addr_q[1:0], ram_rdata) : 32'h0;
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (2 wait states and 0 wait states) checked every
// cycle against a byte-level timing/memory model, plus literal expectations per request.
module tb_dmem_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rd_en     [2];
    logic        wr_en     [2];
    lsuop_t      op        [2];
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic        req_ready [2];
    logic        stall     [2];
    logic        rsp_valid [2];
    logic [31:0] rdata     [2];
    logic        err       [2];

    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .dm_rd_en(rd_en[0]), .dm_wr_en(wr_en[0]),
        .lsuop(op[0]), .addr(addr[0]), .wdata(wdata[0]), .req_ready(req_ready[0]),
        .stall(stall[0]), .rsp_valid(rsp_valid[0]), .rdata(rdata[0]), .err(err[0])
    );

    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .dm_rd_en(rd_en[1]), .dm_wr_en(wr_en[1]),
        .lsuop(op[1]), .addr(addr[1]), .wdata(wdata[1]), .req_ready(req_ready[1]),
        .stall(stall[1]), .rsp_valid(rsp_valid[1]), .rdata(rdata[1]), .err(err[1])
    );

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int wc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    bit          act_m   [2] = '{0, 0};
    int          acc_m   [2];
    bit          m_rd    [2];
    bit          m_wr    [2];
    lsuop_t      m_op    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wd    [2];
    logic [31:0] exp_rd_m  [2];
    bit          exp_err_m [2];
    logic [7:0]  mem_m [2][4096];

    task automatic model_commit(input int d);
        int     size;
        int     ba;
        longint v;
        case (m_op[d])
            LSU_LB, LSU_LBU, LSU_SB: size = 1;
            LSU_LH, LSU_LHU, LSU_SH: size = 2;
            default:                 size = 4;
        endcase
        ba = int'(m_addr[d] % 32'd4096);
        exp_rd_m[d]  = 32'h0;
        exp_err_m[d] = 1'b0;
        if ((m_rd[d] && m_wr[d]) || (ba % size) != 0) begin
            exp_err_m[d] = 1'b1;
        end else if (m_wr[d]) begin
            for (int i = 0; i < size; i++) mem_m[d][ba+i] = 8'(m_wd[d] >> (8*i));
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v = v | (longint'(mem_m[d][ba+i]) << (8*i));
            if ((m_op[d] == LSU_LB || m_op[d] == LSU_LH) && v[8*size-1])
                v = v - (longint'(1) << (8*size));
            exp_rd_m[d] = 32'(v);
        end
    endtask

    initial begin
        bit was_idle;
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    act_m[d] = 1'b0;
                end else begin
                    was_idle = !act_m[d];
                    if (act_m[d] && (cyc - acc_m[d]) == wc(d) + 1) act_m[d] = 1'b0;
                    if (was_idle && (rd_en[d] || wr_en[d])) begin
                        act_m[d]  = 1'b1;
                        acc_m[d]  = cyc;
                        m_rd[d]   = rd_en[d];
                        m_wr[d]   = wr_en[d];
                        m_op[d]   = op[d];
                        m_addr[d] = addr[d];
                        m_wd[d]   = wdata[d];
                    end
                    if (act_m[d] && (cyc - acc_m[d]) == wc(d)) model_commit(d);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        int          k;
        logic        e_ready, e_stall, e_rsp, e_err;
        logic [31:0] e_rdata;
        wait (started);
        forever begin
            @(negedge clk);
            #2;
            for (int d = 0; d < 2; d++) begin
                k = cyc - acc_m[d];
                e_ready = 1'b0; e_stall = 1'b0; e_rsp = 1'b0; e_err = 1'b0; e_rdata = 32'h0;
                if (act_m[d] && k < wc(d)) begin
                    e_stall = 1'b1;
                end else if (act_m[d] && k == wc(d)) begin
                    e_rsp = 1'b1; e_rdata = exp_rd_m[d]; e_err = exp_err_m[d];
                end else begin
                    e_ready = 1'b1;
                    e_stall = rd_en[d] | wr_en[d];
                end
                chk($sformatf("cyc%0d_d%0d_req_ready", cyc, d), 32'(req_ready[d]), 32'(e_ready));
                chk($sformatf("cyc%0d_d%0d_stall", cyc, d), 32'(stall[d]), 32'(e_stall));
                chk($sformatf("cyc%0d_d%0d_rsp_valid", cyc, d), 32'(rsp_valid[d]), 32'(e_rsp));
                chk($sformatf("cyc%0d_d%0d_rdata", cyc, d), rdata[d], e_rdata);
                chk($sformatf("cyc%0d_d%0d_err", cyc, d), 32'(err[d]), 32'(e_err));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_req(input int d, input bit rd, input bit wr, input lsuop_t o,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input bit exp_err, input string nm);
        int lat;
        @(negedge clk);
        rd_en[d] = rd; wr_en[d] = wr; op[d] = o; addr[d] = a; wdata[d] = wd;
        lat = 0;
        @(negedge clk);
        rd_en[d] = 1'b0; wr_en[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid[d]) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no rsp_valid within %0d cycles, required one", nm, lat);
        end else begin
            chk({nm, "_rdata"}, rdata[d], exp_rd);
            chk({nm, "_err"}, 32'(err[d]), 32'(exp_err));
            chk({nm, "_latency"}, lat, wc(d) + 1);
        end
    endtask

    initial begin
        int rsp_cnt;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd_en[d] = 1'b0; wr_en[d] = 1'b0; op[d] = LSU_LW; addr[d] = 32'h0; wdata[d] = 32'h0;
        end
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        started = 1'b1;
        #1;
        chk("reset_req_ready", 32'(req_ready[0]), 32'd1);
        chk("reset_stall", 32'(stall[0]), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("reset_rdata", rdata[0], 32'h0);
        chk("reset_err", 32'(err[0]), 32'd0);

        do_req(0, 0, 1, LSU_SW, 32'h10, 32'hDEADBEEF, 32'h0, 0, "sw_10");
        do_req(0, 1, 0, LSU_LW, 32'h10, 32'h0, 32'hDEADBEEF, 0, "lw_10");

        do_req(0, 0, 1, LSU_SW,  32'h20, 32'h80FF7F01, 32'h0, 0, "sw_20");
        do_req(0, 1, 0, LSU_LB,  32'h23, 32'h0, 32'hFFFFFF80, 0, "lb_23");
        do_req(0, 1, 0, LSU_LBU, 32'h23, 32'h0, 32'h00000080, 0, "lbu_23");
        do_req(0, 1, 0, LSU_LH,  32'h22, 32'h0, 32'hFFFF80FF, 0, "lh_22");
        do_req(0, 1, 0, LSU_LHU, 32'h20, 32'h0, 32'h00007F01, 0, "lhu_20");

        do_req(0, 0, 1, LSU_SW, 32'h30, 32'h0,    32'h0, 0, "sw_30");
        do_req(0, 0, 1, LSU_SB, 32'h31, 32'hAA,   32'h0, 0, "sb_31");
        do_req(0, 1, 0, LSU_LW, 32'h30, 32'h0,    32'h0000AA00, 0, "lw_30_a");
        do_req(0, 0, 1, LSU_SH, 32'h32, 32'h1234, 32'h0, 0, "sh_32");
        do_req(0, 1, 0, LSU_LW, 32'h30, 32'h0,    32'h1234AA00, 0, "lw_30_b");

        do_req(0, 0, 1, LSU_SW, 32'h40, 32'h11223344, 32'h0, 0, "sw_40");
        do_req(0, 1, 0, LSU_LW, 32'h41, 32'h0,        32'h0, 1, "lw_41_misal");
        do_req(0, 1, 0, LSU_LW, 32'h40, 32'h0,        32'h11223344, 0, "lw_40_a");
        do_req(0, 0, 1, LSU_SH, 32'h43, 32'hFFFF,     32'h0, 1, "sh_43_misal");
        do_req(0, 1, 0, LSU_LW, 32'h40, 32'h0,        32'h11223344, 0, "lw_40_b");
        do_req(0, 1, 1, LSU_LW, 32'h40, 32'hFFFFFFFF, 32'h0, 1, "both_en");
        do_req(0, 1, 0, LSU_LW, 32'h40, 32'h0,        32'h11223344, 0, "lw_40_c");

        // Reset lands in WAIT of a store: nothing committed, nothing answered.
        do_req(0, 0, 1, LSU_SW, 32'h50, 32'hCAFEF00D, 32'h0, 0, "sw_50_old");
        @(negedge clk);
        rd_en[0] = 1'b0; wr_en[0] = 1'b1; op[0] = LSU_SW; addr[0] = 32'h50; wdata[0] = 32'h0BADBEEF;
        @(negedge clk);
        wr_en[0] = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        rsp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid[0]) rsp_cnt++;
            @(negedge clk);
        end
        chk("rst_abort_rsp_count", rsp_cnt, 0);
        do_req(0, 1, 0, LSU_LW, 32'h50, 32'h0, 32'hCAFEF00D, 0, "lw_50_after_rst");

        // Zero wait states and address wrap on the second instance.
        do_req(1, 0, 1, LSU_SW, 32'h1000, 32'h5A5AA5A5, 32'h0, 0, "w0_sw_1000");
        do_req(1, 1, 0, LSU_LW, 32'h0,    32'h0, 32'h5A5AA5A5, 0, "w0_lw_0");
        do_req(1, 1, 0, LSU_LH, 32'h1002, 32'h0, 32'h00005A5A, 0, "w0_lh_1002");
        do_req(1, 1, 0, LSU_LB, 32'h0,    32'h0, 32'hFFFFFFA5, 0, "w0_lb_0");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
